// File: rtl/imm_ext_stage.sv
// imm_ext_stage: ID/EX immediate extension with valid/ready and 2-entry skid.
// Ports: i_clk/i_rst_n, i_valid/o_ready/i_immediate/i_mode/i_flush in,
//   o_valid/i_ready/o_imm_ext/o_illegal out; IMM_EXT_BRANCH_TARGET_EN adds i_pc/o_target.
module imm_ext_stage #(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int SHIFT_AMT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [IMM_W-1:0]  i_immediate,
    input  logic [2:0]        i_mode,
`ifdef IMM_EXT_BRANCH_TARGET_EN
    input  logic [DATA_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_target,
`endif
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_imm_ext,
    output logic              o_illegal
);

    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] ext_d;
    logic              ill_d;

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              main_ill;
    logic              skid_v;
    logic [DATA_W-1:0] skid_d;
    logic              skid_ill;
    logic              accept;

    always_comb begin
        zext  = DATA_W'(i_immediate);
        sext  = DATA_W'($signed(i_immediate));
        ext_d = '0;
        ill_d = 1'b0;
        unique case (i_mode)
            3'd0:    ext_d = zext;
            3'd1:    ext_d = sext;
            3'd2:    ext_d = zext << (DATA_W - IMM_W);
            3'd3:    ext_d = sext << SHIFT_AMT;
            3'd4:    ext_d = zext << SHIFT_AMT;
            default: ill_d = 1'b1;
        endcase
    end

    // Ready is purely a function of skid occupancy, so it is a flop output.
    assign o_ready   = !skid_v;
    assign accept    = i_valid && !skid_v;
    assign o_valid   = main_v;
    assign o_imm_ext = main_d;
    assign o_illegal = main_ill;

`ifdef IMM_EXT_BRANCH_TARGET_EN
    // Target is summed once on entry and carried with the entry,
    // so the output is a plain register and resets to zero.
    logic [DATA_W-1:0] tgt_d;
    logic [DATA_W-1:0] main_tgt;
    logic [DATA_W-1:0] skid_tgt;

    assign tgt_d    = i_pc + DATA_W'(4) + ext_d;
    assign o_target = main_tgt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_tgt <= '0;
            skid_tgt <= '0;
        end else if (!i_flush) begin
            if (skid_v) begin
                if (i_ready) main_tgt <= skid_tgt;
            end else if (!main_v || i_ready) begin
                if (accept) main_tgt <= tgt_d;
            end else if (accept) begin
                skid_tgt <= tgt_d;
            end
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_v   <= 1'b0;
            main_d   <= '0;
            main_ill <= 1'b0;
            skid_v   <= 1'b0;
            skid_d   <= '0;
            skid_ill <= 1'b0;
        end else if (i_flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            // Full: only a drain can happen; skid refills main.
            if (i_ready) begin
                main_v   <= 1'b1;
                main_d   <= skid_d;
                main_ill <= skid_ill;
                skid_v   <= 1'b0;
            end
        end else if (!main_v || i_ready) begin
            main_v <= accept;
            if (accept) begin
                main_d   <= ext_d;
                main_ill <= ill_d;
            end
        end else if (accept) begin
            skid_v   <= 1'b1;
            skid_d   <= ext_d;
            skid_ill <= ill_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: vector table, hand sequences and random scoreboard
// for imm_ext_stage at DATA_W=32, IMM_W=16, SHIFT_AMT=2.
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_imm = '0;
    logic [2:0]  i_mode = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_imm_ext;
    logic        o_illegal;
`ifdef IMM_EXT_BRANCH_TARGET_EN
    logic [31:0] i_pc = '0;
    logic [31:0] o_target;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_ext_stage #(.DATA_W(32), .IMM_W(16), .SHIFT_AMT(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_immediate (i_imm),
        .i_mode      (i_mode),
`ifdef IMM_EXT_BRANCH_TARGET_EN
        .i_pc        (i_pc),
        .o_target    (o_target),
`endif
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_imm_ext   (o_imm_ext),
        .o_illegal   (o_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] imm,
                         input logic [2:0] mode, input logic rdy,
                         input logic fl);
        i_valid = v;
        i_imm   = imm;
        i_mode  = mode;
        i_ready = rdy;
        i_flush = fl;
    endtask

    // Reference: arithmetic on the integer value of the immediate.
    function automatic logic [32:0] ref_ext(input logic [15:0] imm,
                                            input logic [2:0] mode);
        longint u;
        longint s;
        longint r;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            3'd0: r = u;
            3'd1: r = s;
            3'd2: r = u * 65536;
            3'd3: r = s * 4;
            3'd4: r = u * 4;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, 32'(r)};
    endfunction

    typedef struct {
        logic [15:0] imm;
        logic [2:0]  mode;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t vecs[8];
    logic [32:0] q[$];

    task automatic drain();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h8001, 3'd0, 32'h00008001, 1'b0};
        vecs[1] = '{16'h8001, 3'd1, 32'hFFFF8001, 1'b0};
        vecs[2] = '{16'h8001, 3'd2, 32'h80010000, 1'b0};
        vecs[3] = '{16'h8001, 3'd3, 32'hFFFE0004, 1'b0};
        vecs[4] = '{16'h8001, 3'd4, 32'h00020004, 1'b0};
        vecs[5] = '{16'h1234, 3'd6, 32'h00000000, 1'b1};
        vecs[6] = '{16'h7FFF, 3'd1, 32'h00007FFF, 1'b0};
        vecs[7] = '{16'hFFFF, 3'd5, 32'h00000000, 1'b1};

        #3;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data", o_imm_ext, 32'd0);
        chk("rst_ill", 32'(o_illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back vectors, i_ready high.
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i - 1), 32'(o_valid), 32'd1);
                chk($sformatf("vec%0d_data", i - 1), o_imm_ext, vecs[i-1].exp);
                chk($sformatf("vec%0d_ill", i - 1), 32'(o_illegal),
                    32'(vecs[i-1].ill));
            end
            if (i < 8) drive(1'b1, vecs[i].imm, vecs[i].mode, 1'b1, 1'b0);
            else drive(1'b0, '0, '0, 1'b1, 1'b0);
            @(negedge clk);
        end
        chk("idle_valid", 32'(o_valid), 32'd0);

        // Back-pressure: A, B fill, C stalls, then drain in order.
        drive(1'b1, 16'h0001, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0002, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_ready_after_b", 32'(o_ready), 32'd0);
        drive(1'b1, 16'h0003, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_full_ready", 32'(o_ready), 32'd0);
        chk("bp_hold_a", o_imm_ext, 32'h1);
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_valid", 32'(o_valid), 32'd1);
        chk("bp_b", o_imm_ext, 32'h2);
        @(negedge clk);
        chk("bp_c_valid", 32'(o_valid), 32'd1);
        chk("bp_c", o_imm_ext, 32'h3);
        i_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", 32'(o_valid), 32'd0);

        // Flush while full, input valid held.
        drive(1'b1, 16'h0011, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0022, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h0033, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("fl_full_valid", 32'(o_valid), 32'd0);
        chk("fl_full_ready", 32'(o_ready), 32'd1);
        // Flush racing an accept into an empty stage.
        drive(1'b1, 16'h0044, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("fl_acc_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("fl_acc_gone", 32'(o_valid), 32'd0);

        // Asynchronous reset mid-burst.
        drive(1'b1, 16'h8888, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h9999, 3'd1, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_data", o_imm_ext, 32'd0);
        chk("arst_ill", 32'(o_illegal), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0055, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk("post_rst_data", o_imm_ext, 32'h55);
        drain();

`ifdef IMM_EXT_BRANCH_TARGET_EN
        i_pc = 32'h0040_0000;
        drive(1'b1, 16'hFFFF, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("target", o_target, 32'h0040_0000);
        drain();
`endif

        // Random traffic against a FIFO model of the stage.
        q.delete();
        for (int c = 0; c < 800; c++) begin
            int occ;
            logic [15:0] imm;
            logic [2:0]  mode;
            logic v, r, f;
            chk("rnd_valid", 32'(o_valid), 32'(q.size() != 0));
            chk("rnd_ready", 32'(o_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                chk("rnd_data", o_imm_ext, q[0][31:0]);
                chk("rnd_ill", 32'(o_illegal), 32'(q[0][32]));
            end
            imm  = 16'($urandom);
            mode = 3'($urandom_range(0, 7));
            v    = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 2) != 0);
            f    = ($urandom_range(0, 39) == 0);
            drive(v, imm, mode, r, f);
            occ = q.size();
            if (occ > 0 && r) void'(q.pop_front());
            if (f) q.delete();
            else if (v && occ < 2) q.push_back(ref_ext(imm, mode));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
Parametrised, pipelined immediate-extension stage for the ID/EX boundary. Accepts a raw instruction immediate plus a mode code and produces a registered DATA_W result. Uses a valid/ready handshake with a 2-entry skid buffer so EX back-pressure never drops an immediate. Supports zero, sign and upper (lui-style) extension, plus shifted branch offsets, with a synchronous flush for branch/exception squash.

Parameters:
DATA_W, 32, output datapath width; legal range DATA_W >= IMM_W.
IMM_W, 16, raw immediate width.
SHIFT_AMT, 2, left shift for the branch-offset modes; result is truncated to DATA_W.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  upstream immediate valid.
o_ready  output  1  stage can accept this cycle.
i_immediate  input  IMM_W  raw immediate.
i_mode  input  3  extension mode (see Behaviour).
i_flush  input  1  squash all held entries.
o_valid  output  1  o_imm_ext valid.
i_ready  input  1  downstream accepts.
o_imm_ext  output  DATA_W  extended result.
o_illegal  output  1  result came from an undefined mode code.

Behaviour:
- Modes (combinational pre-compute, registered on accept):
  - 0: zero-extend.
  - 1: sign-extend from bit IMM_W-1.
  - 2: upper, {imm, (DATA_W-IMM_W) zeros}.
  - 3: sign-extend, then shift left by SHIFT_AMT.
  - 4: zero-extend, then shift left by SHIFT_AMT.
  - 5-7: result 0, illegal flag 1.
  - When DATA_W == IMM_W, modes 0/1/2 pass the immediate unchanged.
- Storage: main register (drives the outputs) plus a skid register. Each entry holds {valid, data, illegal}.
- Accept: i_valid && o_ready. Output transfer: o_valid && i_ready.
- o_ready is registered and equals !skid_valid. It depends only on state, never combinationally on i_ready.
- Accept with main empty, or main draining the same cycle: the new entry loads main. Latency is 1 cycle from accept to o_valid.
- Accept while main is held (o_valid && !i_ready): the entry loads the skid register. o_ready drops the next cycle.
- Main drains while skid is full: skid moves to main and the skid is cleared. No accept is possible that cycle.
- Ordering is strict FIFO. No entry is duplicated or lost.
- Full (both entries valid): o_ready=0. i_valid is ignored.
- Empty: o_valid=0. o_imm_ext holds its last value; it is don't-care for checking but must not be X after reset.
- i_flush: on the next edge both valid bits clear and o_ready=1. Flush beats a simultaneous accept, and the accepted entry is discarded. Data registers are not cleared.
- Reset (async, mid-operation included): all valid bits 0, o_ready=1, o_imm_ext=0, o_illegal=0. Release is synchronous to i_clk; no accept occurs on the release edge.
- Throughput: 1 result/cycle when i_ready stays high.

Optional Feature:
IMM_EXT_BRANCH_TARGET_EN.
- Defined:
  - Adds port i_pc (input, DATA_W) and port o_target (output, DATA_W).
  - i_pc is captured alongside each entry.
  - o_target = captured_pc + 4 + o_imm_ext, modulo 2^DATA_W, computed from registered values.
  - o_target is valid with o_valid, flows through the skid path identically, and resets to 0.
- Undefined: the ports are absent and there is no adder.

Test Plan:
- DATA_W=32, IMM_W=16, i_ready=1; send imm 0x8001 in modes 0, 1, 2, 3, 4 back-to-back -> one cycle later, consecutively:
  - 0x00008001
  - 0xFFFF8001
  - 0x80010000
  - 0xFFFE0004
  - 0x00020004
  - o_illegal=0 throughout.
- Mode 6, imm 0x1234 -> o_imm_ext=0x00000000, o_illegal=1.
- Back-pressure:
  - Send A=0x0001 then B=0x0002 (mode 0) with i_ready=0 -> o_ready=0 after B; C held on input is not accepted.
  - Raise i_ready -> outputs A, B, then C, in order, no gaps after the drain starts.
- Flush while full: i_flush with i_valid high -> next cycle o_valid=0, o_ready=1, and the flushed input never appears.
- Reset: assert i_rst_n=0 asynchronously mid-burst -> o_valid, o_imm_ext, o_illegal clear immediately and o_ready=1. First accept after release appears one cycle later.
- With IMM_EXT_BRANCH_TARGET_EN: i_pc=0x00400000, imm 0xFFFF, mode 3 -> o_target=0x00400000.
